// File: rtl/reg_bus_master.sv
// Register-bus initiator: queues read/write requests in a small FIFO, issues them one at a
// time as single-cycle bus commands and returns one in-order response per request.
module reg_bus_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_op,
  output logic [15:0] rsp_addr,
  output logic [15:0] rsp_rdata,
  output logic        bus_cmd_valid,
  output logic        bus_op,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wr_data,
  input  logic [15:0] bus_rd_data,
  output logic        busy
);

  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(FIFO_DEPTH);
  localparam logic [3:0]  LAT_INIT  = 4'(RD_LATENCY);

  typedef struct packed {
    logic        op;
    logic [15:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  cmd_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, empty, push, pop;
  cmd_t          cmd_q;
  logic [3:0]    lat_cnt;
  logic [15:0]   rdata_q;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign pop   = (state == IDLE) && !empty;
  // A pop frees the head slot this cycle, so a full FIFO can still take one request then.
  assign req_ready = !full || pop;
  assign push      = req_valid && req_ready;

  // NOTE: the storage array is not reset; count alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_op, req_addr, req_wdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = ISSUE;
      ISSUE:   state_nxt = cmd_q.op ? RESP : WAIT;
      WAIT:    if (lat_cnt == 4'd1) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q   <= '0;
      lat_cnt <= '0;
      rdata_q <= '0;
    end else begin
      if (pop) cmd_q <= mem[rd_ptr];
      case (state)
        ISSUE: begin
          if (cmd_q.op) rdata_q <= '0;
          else          lat_cnt <= LAT_INIT;
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == 4'd1) rdata_q <= bus_rd_data;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus_cmd_valid = 1'b0;
    bus_op        = 1'b0;
    bus_addr      = '0;
    bus_wr_data   = '0;
    rsp_valid     = 1'b0;
    rsp_op        = 1'b0;
    rsp_addr      = '0;
    rsp_rdata     = '0;
    case (state)
      ISSUE: begin
        bus_cmd_valid = 1'b1;
        bus_op        = cmd_q.op;
        bus_addr      = cmd_q.addr;
        bus_wr_data   = cmd_q.op ? cmd_q.wdata : 16'h0000;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_op    = cmd_q.op;
        rsp_addr  = cmd_q.addr;
        rsp_rdata = rdata_q;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE) || !empty;

endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: transaction-level scoreboard checked every cycle, an
// invert/passthrough slave model, and directed scenarios with literal expectations.
module tb_reg_bus_master;

  localparam int L = 1;

  typedef struct packed {
    logic        op;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_valid, req_ready, req_op;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_op;
  logic [15:0] rsp_addr, rsp_rdata;
  logic        bus_cmd_valid, bus_op;
  logic [15:0] bus_addr, bus_wr_data;
  logic [15:0] bus_rd_data = '0;
  logic        busy;

  logic        req_valid3, req_ready3, req_op3;
  logic [15:0] req_addr3, req_wdata3;
  logic        rsp_valid3, rsp_ready3, rsp_op3;
  logic [15:0] rsp_addr3, rsp_rdata3;
  logic        bus_cmd_valid3, bus_op3;
  logic [15:0] bus_addr3, bus_wr_data3, bus_rd_data3;
  logic        busy3;

  reg_bus_master #(.FIFO_DEPTH(4), .RD_LATENCY(L)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
    .bus_cmd_valid(bus_cmd_valid), .bus_op(bus_op), .bus_addr(bus_addr),
    .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .busy(busy)
  );

  reg_bus_master #(.FIFO_DEPTH(4), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op3),
    .req_addr(req_addr3), .req_wdata(req_wdata3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_op(rsp_op3),
    .rsp_addr(rsp_addr3), .rsp_rdata(rsp_rdata3),
    .bus_cmd_valid(bus_cmd_valid3), .bus_op(bus_op3), .bus_addr(bus_addr3),
    .bus_wr_data(bus_wr_data3), .bus_rd_data(bus_rd_data3), .busy(busy3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Invert/passthrough slave: register 0x0009 bit 0 selects inversion, everything else reads 0.
  logic inv_bit = 1'b0;
  always @(posedge clk) begin
    bus_rd_data <= 16'h0000;
    if (bus_cmd_valid && bus_op && bus_addr == 16'h0009) inv_bit <= bus_wr_data[0];
    if (bus_cmd_valid && !bus_op && bus_addr == 16'h0009) bus_rd_data <= {15'b0, inv_bit};
  end

  function automatic logic [7:0] datapath(input logic [7:0] b);
    return inv_bit ? ~b : b;
  endfunction

  // Slave for the latency-3 instance: read data is valid only in the third cycle after the strobe.
  int since3 = 0;
  always @(posedge clk) begin
    if (bus_cmd_valid3)   since3 <= 1;
    else if (since3 != 0) since3 <= since3 + 1;
  end
  assign bus_rd_data3 = (since3 == 3) ? 16'hBEEF : 16'h0000;

  // Scoreboard state: accepted-but-not-issued requests, the one outstanding command, logs.
  txn_t        pend_q[$];
  int          pend_cyc[$];
  bit          out_v = 1'b0;
  txn_t        out_r;
  int          out_strobe, out_rsp_time;
  logic [15:0] out_rdata;
  int          last_hs = -100;
  int          n_acc = 0, n_rsp = 0;
  txn_t        rsp_log[$];
  int          rsp_cyc_log[$], acc_cyc_log[$], strobe_cyc_log[$];
  bit          exp_strobe, exp_rv;
  int          ready_at;

  always @(negedge clk) begin
    if (rst) begin
      pend_q.delete();
      pend_cyc.delete();
      out_v   = 1'b0;
      n_acc   = 0;
      n_rsp   = 0;
      last_hs = -100;
    end else begin
      check("busy", busy, n_acc > n_rsp);

      exp_strobe = 1'b0;
      if (!out_v && pend_q.size() > 0) begin
        ready_at = pend_cyc[0] + 2;
        if (last_hs + 2 > ready_at) ready_at = last_hs + 2;
        exp_strobe = (cyc >= ready_at);
      end
      check("bus_cmd_valid", bus_cmd_valid, exp_strobe);

      if (bus_cmd_valid && pend_q.size() > 0) begin
        check("bus_op", bus_op, pend_q[0].op);
        check("bus_addr", bus_addr, pend_q[0].addr);
        if (pend_q[0].op) check("bus_wr_data", bus_wr_data, pend_q[0].data);
        out_r = pend_q.pop_front();
        void'(pend_cyc.pop_front());
        out_v        = 1'b1;
        out_strobe   = cyc;
        out_rsp_time = cyc + 1 + (out_r.op ? 0 : L);
        out_rdata    = 16'h0000;
        strobe_cyc_log.push_back(cyc);
      end else if (!bus_cmd_valid) begin
        check("bus_idle", {bus_op, bus_addr, bus_wr_data}, 33'd0);
      end

      if (out_v && !out_r.op && cyc == out_strobe + L) out_rdata = bus_rd_data;

      exp_rv = out_v && (cyc >= out_rsp_time);
      check("rsp_valid", rsp_valid, exp_rv);
      if (rsp_valid && exp_rv) begin
        check("rsp_op", rsp_op, out_r.op);
        check("rsp_addr", rsp_addr, out_r.addr);
        check("rsp_rdata", rsp_rdata, out_rdata);
        if (rsp_ready) begin
          out_v   = 1'b0;
          n_rsp++;
          last_hs = cyc;
          rsp_log.push_back({rsp_op, rsp_addr, rsp_rdata});
          rsp_cyc_log.push_back(cyc);
        end
      end

      if (req_valid && req_ready) begin
        pend_q.push_back({req_op, req_addr, req_wdata});
        pend_cyc.push_back(cyc);
        n_acc++;
        acc_cyc_log.push_back(cyc);
      end
    end
  end

  task automatic clear_logs();
    rsp_log.delete();
    rsp_cyc_log.delete();
    acc_cyc_log.delete();
    strobe_cyc_log.delete();
  endtask

  // Called just after a rising edge; returns just after the edge that completes the handshake.
  task automatic send(input logic op, input logic [15:0] addr, input logic [15:0] data);
    bit done;
    done      = 1'b0;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = data;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200 && (out_v || pend_q.size() > 0); k++) begin
      @(posedge clk);
      #1;
    end
    if (k == 200) check("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  int acc_cnt, strobe3, rv3;
  logic [15:0] rd3;
  bit acc3;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_op = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    req_valid3 = 1'b0; req_op3 = 1'b0; req_addr3 = '0; req_wdata3 = '0; rsp_ready3 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_bus_cmd_valid", bus_cmd_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 16'h0);
    check("rst3_req_ready", req_ready3, 1'b1);
    @(posedge clk);
    #1;

    // Write then read back through the invert/passthrough slave
    clear_logs();
    send(1'b1, 16'h0009, 16'h0001);
    send(1'b0, 16'h0009, 16'h0000);
    wait_idle();
    check("wr_rd_rsp_count", rsp_log.size(), 2);
    check("wr_rsp", rsp_log[0], {1'b1, 16'h0009, 16'h0000});
    check("rd_rsp", rsp_log[1], {1'b0, 16'h0009, 16'h0001});
    check("wr_strobe_latency", strobe_cyc_log[0] - acc_cyc_log[0], 2);
    check("wr_rsp_latency", rsp_cyc_log[0] - strobe_cyc_log[0], 1);
    check("rd_rsp_latency", rsp_cyc_log[1] - strobe_cyc_log[1], 1 + L);
    check("datapath_invert", datapath(8'h5A), 8'hA5);

    // Unmapped address reads zero and leaves the invert bit alone
    clear_logs();
    send(1'b1, 16'h0003, 16'hFFFF);
    send(1'b0, 16'h0003, 16'h0000);
    send(1'b0, 16'h0009, 16'h0000);
    wait_idle();
    check("unmapped_rd", rsp_log[1], {1'b0, 16'h0003, 16'h0000});
    check("invert_kept", rsp_log[2], {1'b0, 16'h0009, 16'h0001});

    // Back-pressure: 7 back-to-back writes with responses stalled
    clear_logs();
    rsp_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      req_valid = 1'b1;
      req_op    = 1'b1;
      req_addr  = 16'h0100 + 16'(i);
      req_wdata = 16'h1000 + 16'(i);
      @(negedge clk);
      if (req_ready) acc_cnt++;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    check("bp_accepted", acc_cnt, 5);
    @(negedge clk);
    check("bp_req_ready_low", req_ready, 1'b0);
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_single_strobe", strobe_cyc_log.size(), 1);

    // Full FIFO: new request accepted in the same cycle the FSM pops the head
    rsp_ready = 1'b1;
    send(1'b1, 16'h01A0, 16'hA0A0);
    check("full_push_pop_cycle", acc_cyc_log[5] - rsp_cyc_log[0], 1);
    @(negedge clk);
    check("full_count_kept", req_ready, 1'b0);
    @(posedge clk);
    #1;
    wait_idle();
    check("bp_rsp_count", rsp_log.size(), 6);
    for (int i = 0; i < 5; i++) check("bp_rsp_order", rsp_log[i].addr, 16'h0100 + 16'(i));
    check("wrap_rsp_addr", rsp_log[5].addr, 16'h01A0);
    check("bp_strobe_count", strobe_cyc_log.size(), 6);

    // Reset while a read waits with two more entries queued
    clear_logs();
    send(1'b0, 16'h0009, 16'h0000);
    send(1'b0, 16'h0003, 16'h0000);
    send(1'b0, 16'h0010, 16'h0000);
    check("pre_rst_strobes", strobe_cyc_log.size(), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_req_ready", req_ready, 1'b1);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_bus_cmd_valid", bus_cmd_valid, 1'b0);
    @(posedge clk);
    #1;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_no_strobe", strobe_cyc_log.size(), 1);
    check("post_rst_no_rsp", rsp_log.size(), 0);
    send(1'b1, 16'h0009, 16'h0000);
    wait_idle();
    check("post_rst_new_strobe", strobe_cyc_log.size(), 2);
    check("post_rst_rsp", rsp_log[0], {1'b1, 16'h0009, 16'h0000});

    // Read latency 3 on the second instance
    req_valid3 = 1'b1;
    req_op3    = 1'b0;
    req_addr3  = 16'h0042;
    strobe3    = -1;
    rv3        = -1;
    rd3        = 16'h0000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      acc3 = req_valid3 && req_ready3;
      if (bus_cmd_valid3 && strobe3 < 0) begin
        strobe3 = cyc;
        check("lat3_bus_op", bus_op3, 1'b0);
        check("lat3_bus_addr", bus_addr3, 16'h0042);
      end
      if (rsp_valid3 && rv3 < 0) begin
        rv3 = cyc;
        rd3 = rsp_rdata3;
      end
      @(posedge clk);
      #1;
      if (acc3) req_valid3 = 1'b0;
    end
    check("lat3_strobe_seen", strobe3 >= 0, 1'b1);
    check("lat3_rdata", rd3, 16'hBEEF);
    check("lat3_rsp_delay", rv3 - strobe3, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
